// File: rtl/midi_voice_alloc_pkg.sv
// midi_pkg: MIDI status constants and parser state encoding shared by the voice allocator.
package midi_pkg;
    localparam logic [3:0] NOTE_OFF     = 4'h8;
    localparam logic [3:0] NOTE_ON      = 4'h9;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;
    typedef enum logic [1:0] {WAIT_STATUS, WAIT_D1, WAIT_D2, SKIP} parse_state_e;
endpackage

// File: rtl/midi_msg_parser.sv
// midi_msg_parser: note-on/off parser with running status; msg_valid pulses in the cycle the velocity byte arrives.
module midi_msg_parser import midi_pkg::*; #(
    parameter int MIDI_CHANNEL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_byte,
    input  logic       i_valid,
    output logic [6:0] o_note,
    output logic [6:0] o_velocity,
    output logic       o_is_on,
    output logic       o_msg_valid
);
    parse_state_e r_state, w_next;
    logic         r_run_on;
    logic [6:0]   r_note;
    logic         w_take, w_status, w_ours;
    // Realtime bytes are invisible to the parser: they neither advance state nor touch running status.
    assign w_take   = i_valid && (i_byte < REALTIME_MIN);
    assign w_status = i_byte[7];
    assign w_ours   = (i_byte[7:4] == NOTE_OFF || i_byte[7:4] == NOTE_ON) && i_byte[3:0] == 4'(MIDI_CHANNEL);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= WAIT_STATUS;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (w_take && w_status) w_next = w_ours ? WAIT_D1 : SKIP;
        else if (w_take && r_state == WAIT_D1) w_next = WAIT_D2;
        else if (w_take && r_state == WAIT_D2) w_next = WAIT_D1;
    end
    always_comb begin
        o_msg_valid = w_take && !w_status && r_state == WAIT_D2;
        o_note      = r_note;
        o_velocity  = i_byte[6:0];
        o_is_on     = r_run_on;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run_on <= 1'b0;
            r_note   <= '0;
        end else begin
            if (w_take && w_status) r_run_on <= w_ours && i_byte[7:4] == NOTE_ON;
            if (w_take && !w_status && r_state == WAIT_D1) r_note <= i_byte[6:0];
        end
    end
endmodule

// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: polyphonic voice allocator (retrigger, lowest-free, round-robin steal) fed by a MIDI parser.
module midi_voice_alloc import midi_pkg::*; #(
    parameter int NUMVOICES    = 4,
    parameter int MIDI_CHANNEL = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           midi_byte,
    input  logic                 midi_byte_valid,
    output logic [6:0]           midi_notenums  [0:NUMVOICES-1],
    output logic [6:0]           voice_velocity [0:NUMVOICES-1],
    output logic [NUMVOICES-1:0] voice_gate,
    output logic [NUMVOICES-1:0] voice_trig
);
    localparam int PW = NUMVOICES > 1 ? $clog2(NUMVOICES) : 1;
    logic [6:0]           w_note, w_vel;
    logic                 w_is_on, w_msg_valid, w_note_on, w_steal;
    logic [6:0]           r_note [0:NUMVOICES-1];
    logic [6:0]           r_vel  [0:NUMVOICES-1];
    logic [NUMVOICES-1:0] r_gate, r_trig, w_match;
    logic [PW-1:0]        r_steal_ptr, w_hit_idx, w_free_idx, w_tgt;
    midi_msg_parser #(.MIDI_CHANNEL(MIDI_CHANNEL)) u_parser (
        .clk        (clk),
        .reset      (reset),
        .i_byte     (midi_byte),
        .i_valid    (midi_byte_valid),
        .o_note     (w_note),
        .o_velocity (w_vel),
        .o_is_on    (w_is_on),
        .o_msg_valid(w_msg_valid)
    );
    for (genvar v = 0; v < NUMVOICES; v++) begin : g_match
        assign w_match[v] = r_gate[v] && r_note[v] == w_note;
    end
    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        w_hit_idx  = '0;
        w_free_idx = '0;
        for (int i = NUMVOICES - 1; i >= 0; i--) begin
            if (w_match[i]) w_hit_idx = PW'(i);
            if (!r_gate[i]) w_free_idx = PW'(i);
        end
        w_steal   = ~|w_match && &r_gate;
        w_tgt     = |w_match ? w_hit_idx : (w_steal ? r_steal_ptr : w_free_idx);
        w_note_on = w_is_on && w_vel != 7'd0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUMVOICES; i++) begin
                r_note[i] <= '0;
                r_vel[i]  <= '0;
            end
            r_gate      <= '0;
            r_trig      <= '0;
            r_steal_ptr <= '0;
        end else begin
            r_trig <= '0;
            if (w_msg_valid && w_note_on) begin
                r_note[w_tgt] <= w_note;
                r_vel[w_tgt]  <= w_vel;
                r_gate[w_tgt] <= 1'b1;
                r_trig[w_tgt] <= 1'b1;
                if (w_steal) r_steal_ptr <= r_steal_ptr == PW'(NUMVOICES - 1) ? '0 : r_steal_ptr + 1'b1;
            end else if (w_msg_valid) begin
                r_gate <= r_gate & ~w_match;
            end
        end
    end
    assign midi_notenums  = r_note;
    assign voice_velocity = r_vel;
    assign voice_gate     = r_gate;
    assign voice_trig     = r_trig;
endmodule
